id_ex_pipe_reg: RTL

//  ID/EX pipeline register feeding the execute stage (yEX): captures decoded operands, immediate,
//  ALU op, ALUSrc and downstream control, and holds them stable while EX/MEM back-pressures.

---
 rtl/id_ex_pipe_reg.sv | 125 ++++++++++++
 1 files changed

// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline register with load-use bubble insertion, branch flush and bubble counter.
// Latency: 1 cycle from accept to out_valid; 1 instruction/cycle absent hazards and stalls.
// Backpressure: when out_ready is low a held instruction stays frozen and in_ready drops.
module id_ex_pipe_reg #(
    parameter int DW   = 32,
    parameter int RW   = 5,
    parameter int CNTW = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [DW-1:0]   id_pc,
    input  logic [DW-1:0]   id_rd1,
    input  logic [DW-1:0]   id_rd2,
    input  logic [DW-1:0]   id_imm,
    input  logic [2:0]      id_op,
    input  logic            id_alusrc,
    input  logic [RW-1:0]   id_rs1,
    input  logic [RW-1:0]   id_rs2,
    input  logic [RW-1:0]   id_rd,
    input  logic            id_regwrite,
    input  logic            id_memread,
    input  logic            id_memwrite,
    input  logic            id_branch,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [DW-1:0]   ex_pc,
    output logic [DW-1:0]   ex_rd1,
    output logic [DW-1:0]   ex_rd2,
    output logic [DW-1:0]   ex_imm,
    output logic [2:0]      ex_op,
    output logic            ex_alusrc,
    output logic [RW-1:0]   ex_rs1,
    output logic [RW-1:0]   ex_rs2,
    output logic [RW-1:0]   ex_rd,
    output logic            ex_regwrite,
    output logic            ex_memread,
    output logic            ex_memwrite,
    output logic            ex_branch,
    output logic [CNTW-1:0] bubble_cnt
);

    localparam logic [1:0] S_EMPTY  = 2'd0;
    localparam logic [1:0] S_FULL   = 2'd1;
    localparam logic [1:0] S_BUBBLE = 2'd2;

    logic [1:0] state;
    logic       adv;
    logic       rs2_used;
    logic       hazard;
    logic       bubble_ins;
    logic       clr_ex;
    logic       load_ex;

    assign out_valid = (state == S_FULL);
    assign adv       = !out_valid || out_ready;

    // rs2 only matters when it feeds the ALU or supplies store data
    assign rs2_used  = !id_alusrc || id_memwrite;
    assign hazard    = out_valid && ex_memread && (ex_rd != '0) && in_valid &&
                       ((id_rs1 == ex_rd) || ((id_rs2 == ex_rd) && rs2_used));
    assign in_ready  = adv && !hazard && !flush;

    assign bubble_ins = !flush && hazard && adv;
    assign clr_ex     = flush || bubble_ins;
    assign load_ex    = !flush && !hazard && adv && in_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_EMPTY;
        end else if (flush) begin
            state <= S_EMPTY;
        end else if (hazard) begin
            if (adv) begin
                state <= S_BUBBLE;
            end
        end else if (adv) begin
            state <= in_valid ? S_FULL : S_EMPTY;
        end
    end

    // ex_* hold their last contents when the slot simply drains empty
    always_ff @(posedge clk) begin
        if (rst || clr_ex) begin
            ex_pc       <= '0;
            ex_rd1      <= '0;
            ex_rd2      <= '0;
            ex_imm      <= '0;
            ex_op       <= '0;
            ex_alusrc   <= 1'b0;
            ex_rs1      <= '0;
            ex_rs2      <= '0;
            ex_rd       <= '0;
            ex_regwrite <= 1'b0;
            ex_memread  <= 1'b0;
            ex_memwrite <= 1'b0;
            ex_branch   <= 1'b0;
        end else if (load_ex) begin
            ex_pc       <= id_pc;
            ex_rd1      <= id_rd1;
            ex_rd2      <= id_rd2;
            ex_imm      <= id_imm;
            ex_op       <= id_op;
            ex_alusrc   <= id_alusrc;
            ex_rs1      <= id_rs1;
            ex_rs2      <= id_rs2;
            ex_rd       <= id_rd;
            ex_regwrite <= id_regwrite;
            ex_memread  <= id_memread;
            ex_memwrite <= id_memwrite;
            ex_branch   <= id_branch;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bubble_cnt <= '0;
        end else if (bubble_ins && (bubble_cnt != {CNTW{1'b1}})) begin
            bubble_cnt <= bubble_cnt + CNTW'(1);
        end
    end

endmodule
